// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 opcode constants, immediate format enum and
// immediate extraction helpers.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            OP_OP:                    return FMT_R;
            default:                  return FMT_NONE;
        endcase
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // 32-bit sign-extended immediate; callers widen with a signed cast.
    function automatic logic [31:0] fmt_imm(input fmt_e fmt, input logic [31:0] instr);
        case (fmt)
            FMT_I:   return imm_i(instr);
            FMT_S:   return imm_s(instr);
            FMT_B:   return imm_b(instr);
            FMT_U:   return imm_u(instr);
            FMT_J:   return imm_j(instr);
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register busy scoreboard and RAW/WAW hazard evaluation.
// Honours DECODE_BYPASS_EN: a source being written back this cycle is not busy.
module decode_scoreboard #(
    parameter int unsigned RegCount = 32,
    localparam int unsigned RegSel  = $clog2(RegCount)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_i,
    input  logic [RegSel-1:0] rs1_i,
    input  logic              rs1_used_i,
    input  logic [RegSel-1:0] rs2_i,
    input  logic              rs2_used_i,
    input  logic [RegSel-1:0] rd_i,
    input  logic              rd_we_i,
    input  logic              wb_valid_i,
    input  logic [RegSel-1:0] wb_reg_i,
    output logic              hazard_o
);

    logic [RegCount-1:0] busy_q, busy_d;
    logic                rs1_busy, rs2_busy;

    // Issue is applied after the write-back clear so that set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) busy_d[wb_reg_i] = 1'b0;
        if (issue_i && rd_we_i) busy_d[rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    always_comb begin
        rs1_busy = busy_q[rs1_i];
        rs2_busy = busy_q[rs2_i];
`ifdef DECODE_BYPASS_EN
        if (wb_valid_i && (wb_reg_i == rs1_i)) rs1_busy = 1'b0;
        if (wb_valid_i && (wb_reg_i == rs2_i)) rs2_busy = 1'b0;
`endif
        hazard_o = (rs1_used_i && rs1_busy) || (rs2_used_i && rs2_busy) ||
                   (rd_we_i && busy_q[rd_i]);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry decode slot, integer register file and hazard stall.
// Define DECODE_BYPASS_EN to forward same-cycle write-back data to operands.
module decode_stage
    import decode_pkg::*;
#(
    parameter int          CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned REG_COUNT    = 32,
    localparam int unsigned REG_SEL     = $clog2(REG_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] in_pc,
    input  logic [31:0]             in_instruction,
    input  logic                    flush,
    input  logic                    wb_valid,
    input  logic [REG_SEL-1:0]      wb_reg,
    input  logic [DATA_WIDTH-1:0]   wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_pc,
    output logic [6:0]              out_opcode,
    output logic [2:0]              out_funct3,
    output logic [6:0]              out_funct7,
    output logic [REG_SEL-1:0]      out_rd,
    output logic [DATA_WIDTH-1:0]   out_rs1_data,
    output logic [DATA_WIDTH-1:0]   out_rs2_data,
    output logic [DATA_WIDTH-1:0]   out_imm,
    output logic                    out_rd_we,
    output logic [ADDRESS_BITS-1:0] out_branch_target,
    output logic [ADDRESS_BITS-1:0] out_jal_target
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("decode_stage: DATA_WIDTH must be 32 or 64");
    end
    if (CORE < 0) begin : g_bad_core
        $error("decode_stage: CORE index must be non-negative");
    end

    logic                    slot_valid_q, slot_valid_d;
    logic [ADDRESS_BITS-1:0] slot_pc_q, slot_pc_d;
    logic [31:0]             slot_instr_q, slot_instr_d;
    logic [DATA_WIDTH-1:0]   regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]   regs_d [REG_COUNT];

    fmt_e               fmt;
    logic [REG_SEL-1:0] rs1, rs2, rd;
    logic               rs1_used, rs2_used, rd_we;
    logic               hazard, issue, accept;

    assign rs1 = slot_instr_q[15 +: REG_SEL];
    assign rs2 = slot_instr_q[20 +: REG_SEL];
    assign rd  = slot_instr_q[7 +: REG_SEL];

    always_comb begin
        fmt      = opcode_fmt(slot_instr_q[6:0]);
        rs1_used = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        rs2_used = fmt inside {FMT_R, FMT_S, FMT_B};
        rd_we    = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (rd != '0);
    end

    assign out_valid = slot_valid_q && !hazard && !flush;
    assign issue     = out_valid && out_ready;
    assign in_ready  = !flush && (!slot_valid_q || issue);
    assign accept    = in_valid && in_ready;

    decode_scoreboard #(
        .RegCount(REG_COUNT)
    ) u_scoreboard (
        .clk_i     (clock),
        .rst_ni    (reset),
        .issue_i   (issue),
        .rs1_i     (rs1),
        .rs1_used_i(rs1_used),
        .rs2_i     (rs2),
        .rs2_used_i(rs2_used),
        .rd_i      (rd),
        .rd_we_i   (rd_we),
        .wb_valid_i(wb_valid),
        .wb_reg_i  (wb_reg),
        .hazard_o  (hazard)
    );

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        if (flush) begin
            slot_valid_d = 1'b0;
        end else if (accept) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = in_pc;
            slot_instr_d = in_instruction;
        end else if (issue) begin
            slot_valid_d = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_valid && (wb_reg != '0)) regs_d[wb_reg] = wb_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            regs_q       <= regs_d;
        end
    end

    // Targets use the B/J encodings unconditionally; execute picks the relevant one.
    always_comb begin
        out_pc            = slot_pc_q;
        out_opcode        = slot_instr_q[6:0];
        out_funct3        = slot_instr_q[14:12];
        out_funct7        = slot_instr_q[31:25];
        out_rd            = rd;
        out_rd_we         = rd_we;
        out_imm           = DATA_WIDTH'($signed(fmt_imm(fmt, slot_instr_q)));
        out_branch_target = slot_pc_q + ADDRESS_BITS'($signed(imm_b(slot_instr_q)));
        out_jal_target    = slot_pc_q + ADDRESS_BITS'($signed(imm_j(slot_instr_q)));
        out_rs1_data      = (rs1 == '0) ? '0 : regs_q[rs1];
        out_rs2_data      = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef DECODE_BYPASS_EN
        if (wb_valid && (wb_reg != '0) && (wb_reg == rs1)) out_rs1_data = wb_data;
        if (wb_valid && (wb_reg != '0) && (wb_reg == rs2)) out_rs2_data = wb_data;
`endif
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: per-cycle comparison against a
// behavioural model plus directed literal expectations.
module tb_decode_stage;

    localparam int DW = 32;
    localparam int AB = 20;
    localparam int RC = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid, in_ready, flush, wb_valid, out_valid, out_ready, out_rd_we;
    logic [AB-1:0] in_pc, out_pc, out_branch_target, out_jal_target;
    logic [31:0]   in_instruction;
    logic [4:0]    wb_reg, out_rd;
    logic [DW-1:0] wb_data, out_rs1_data, out_rs2_data, out_imm;
    logic [6:0]    out_opcode, out_funct7;
    logic [2:0]    out_funct3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decode_stage #(
        .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .REG_COUNT(RC)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instruction(in_instruction), .flush(flush),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_rd_we(out_rd_we),
        .out_branch_target(out_branch_target), .out_jal_target(out_jal_target)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [RC];
    bit            m_busy [RC];
    bit            m_slot_valid;
    logic [AB-1:0] m_slot_pc;
    logic [31:0]   m_slot_instr;
    bit            e_ov, e_ir, e_rd_we;
    logic [DW-1:0] e_rs1, e_rs2, e_imm;
    logic [AB-1:0] e_bt, e_jt;

    function automatic string fmt_of(input logic [6:0] op);
        case (op)
            7'h03, 7'h13, 7'h67: return "I";
            7'h23:               return "S";
            7'h63:               return "B";
            7'h37, 7'h17:        return "U";
            7'h6F:               return "J";
            7'h33:               return "R";
            default:             return "-";
        endcase
    endfunction

    function automatic longint imm_of(input logic [31:0] ins, input string f);
        longint v;
        v = 0;
        if (f == "I") v = longint'($signed(ins)) >>> 20;
        else if (f == "S") v = (longint'($signed(ins)) >>> 25) * 32 + longint'(ins[11:7]);
        else if (f == "B") begin
            v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            if (ins[31]) v = v - 8192;
        end else if (f == "J") begin
            v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            if (ins[31]) v = v - 2097152;
        end else if (f == "U") v = longint'($signed(ins & 32'hFFFFF000));
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RC; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_slot_valid = 1'b0;
        m_slot_pc    = '0;
        m_slot_instr = '0;
    endtask

    task automatic model_eval();
        string f;
        int    r1, r2, rd;
        bit    u1, u2, b1, b2;
        f  = fmt_of(m_slot_instr[6:0]);
        r1 = int'(m_slot_instr[19:15]);
        r2 = int'(m_slot_instr[24:20]);
        rd = int'(m_slot_instr[11:7]);
        u1 = (f == "R") || (f == "I") || (f == "S") || (f == "B");
        u2 = (f == "R") || (f == "S") || (f == "B");
        b1 = m_busy[r1];
        b2 = m_busy[r2];
        e_rs1 = (r1 == 0) ? '0 : m_regs[r1];
        e_rs2 = (r2 == 0) ? '0 : m_regs[r2];
`ifdef DECODE_BYPASS_EN
        if (wb_valid && r1 != 0 && int'(wb_reg) == r1) begin b1 = 1'b0; e_rs1 = wb_data; end
        if (wb_valid && r2 != 0 && int'(wb_reg) == r2) begin b2 = 1'b0; e_rs2 = wb_data; end
`endif
        e_rd_we = ((f == "R") || (f == "I") || (f == "U") || (f == "J")) && rd != 0;
        e_ov  = m_slot_valid && !((u1 && b1) || (u2 && b2) || (e_rd_we && m_busy[rd])) && !flush;
        e_ir  = !flush && (!m_slot_valid || (e_ov && out_ready));
        e_imm = DW'(imm_of(m_slot_instr, f));
        e_bt  = AB'(longint'(m_slot_pc) + imm_of(m_slot_instr, "B"));
        e_jt  = AB'(longint'(m_slot_pc) + imm_of(m_slot_instr, "J"));
    endtask

    task automatic model_update();
        int rd;
        rd = int'(m_slot_instr[11:7]);
        if (wb_valid) begin
            m_busy[wb_reg] = 1'b0;
            if (wb_reg != 0) m_regs[wb_reg] = wb_data;
        end
        if (e_ov && out_ready && e_rd_we) m_busy[rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (flush) m_slot_valid = 1'b0;
        else if (in_valid && e_ir) begin
            m_slot_valid = 1'b1;
            m_slot_pc    = in_pc;
            m_slot_instr = in_instruction;
        end else if (e_ov && out_ready) m_slot_valid = 1'b0;
    endtask

    // Compare 4 time units after the driving negedge, update on the posedge.
    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            #4;
            if (reset) begin
                model_eval();
                chk("out_valid", out_valid, e_ov);
                chk("in_ready", in_ready, e_ir);
                if (e_ov) begin
                    chk("out_pc", out_pc, m_slot_pc);
                    chk("out_opcode", out_opcode, m_slot_instr[6:0]);
                    chk("out_funct3", out_funct3, m_slot_instr[14:12]);
                    chk("out_funct7", out_funct7, m_slot_instr[31:25]);
                    chk("out_rd", out_rd, m_slot_instr[11:7]);
                    chk("out_rd_we", out_rd_we, e_rd_we);
                    chk("out_rs1_data", out_rs1_data, e_rs1);
                    chk("out_rs2_data", out_rs2_data, e_rs2);
                    chk("out_imm", out_imm, e_imm);
                    chk("out_branch_target", out_branch_target, e_bt);
                    chk("out_jal_target", out_jal_target, e_jt);
                end
            end
            @(posedge clock);
            if (!reset) model_reset();
            else        model_update();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic put(input logic [AB-1:0] pc, input logic [31:0] ins);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_instruction = ins;
    endtask

    initial begin
        in_valid = 0; in_pc = '0; in_instruction = '0; flush = 0;
        wb_valid = 0; wb_reg = '0; wb_data = '0; out_ready = 1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #4;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_opcode", out_opcode, 0);
        chk("rst_out_rd_we", out_rd_we, 0);
        chk("rst_branch_target", out_branch_target, 0);
        chk("rst_jal_target", out_jal_target, 0);

        // addi x5,x0,0
        @(negedge clock); put(20'h10, 32'h00000293);
        @(negedge clock); in_valid = 0; #4;
        chk("addi5_valid", out_valid, 1);
        chk("addi5_rs1", out_rs1_data, 0);
        chk("addi5_rd", out_rd, 5);

        // addi x1,x0,5 then add x2,x1,x1 (RAW)
        @(negedge clock); put(20'h100, 32'h00500093);
        @(negedge clock); put(20'h104, 32'h00108133); #4;
        chk("addi1_valid", out_valid, 1);
        chk("addi1_opcode", out_opcode, 7'b0010011);
        chk("addi1_rd", out_rd, 1);
        chk("addi1_imm", out_imm, 5);
        chk("addi1_rd_we", out_rd_we, 1);
        @(negedge clock); in_valid = 0; #4;
        chk("raw_stall_valid", out_valid, 0);
        chk("raw_stall_in_ready", in_ready, 0);
        @(negedge clock); wb_valid = 1; wb_reg = 5'd1; wb_data = 7; #4;
`ifdef DECODE_BYPASS_EN
        chk("raw_wb_cycle_valid", out_valid, 1);
        chk("raw_bypass_rs1", out_rs1_data, 7);
        chk("raw_bypass_rs2", out_rs2_data, 7);
`else
        chk("raw_wb_cycle_valid", out_valid, 0);
`endif
        @(negedge clock); wb_valid = 0; #4;
`ifdef DECODE_BYPASS_EN
        chk("raw_after_wb_valid", out_valid, 0);
`else
        chk("raw_after_wb_valid", out_valid, 1);
        chk("raw_rs1", out_rs1_data, 7);
        chk("raw_rs2", out_rs2_data, 7);
`endif

        // beq x0,x0,-8 then jal x1,16 under backpressure
        @(negedge clock); put(20'h200, 32'hFE000CE3);
        @(negedge clock); put(20'h300, 32'h010000EF); #4;
        chk("beq_valid", out_valid, 1);
        chk("beq_imm", out_imm, 32'hFFFFFFF8);
        chk("beq_target", out_branch_target, 20'h1F8);
        chk("beq_rd_we", out_rd_we, 0);
        @(negedge clock); out_ready = 0; put(20'h400, 32'h00000013);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            #4;
            chk("jal_hold_valid", out_valid, 1);
            chk("jal_hold_in_ready", in_ready, 0);
            chk("jal_target", out_jal_target, 20'h310);
            chk("jal_rd_we", out_rd_we, 1);
            chk("jal_hold_pc", out_pc, 20'h300);
        end
        @(negedge clock); flush = 1; #4;
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 0);
        @(negedge clock); flush = 0; in_valid = 0; out_ready = 1; #4;
        chk("post_flush_valid", out_valid, 0);
        chk("post_flush_in_ready", in_ready, 1);

        // add x3,x1,x1: x1 not busy (flushed jal never issued)
        @(negedge clock); put(20'h500, 32'h001081B3);
        @(negedge clock); put(20'h504, 32'h00028413); #4;
        chk("add3_valid", out_valid, 1);
        chk("add3_rs1", out_rs1_data, 7);
        // addi x8,x5,0: x5 still busy across the flush
        @(negedge clock); in_valid = 0; #4;
        chk("x5_busy_valid", out_valid, 0);

        // reset mid-operation
        @(negedge clock); reset = 0; #4;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clock); reset = 1; put(20'h500, 32'h00028413);
        @(negedge clock); put(20'h504, 32'h001081B3); #4;
        chk("after_rst_valid", out_valid, 1);
        chk("after_rst_rd", out_rd, 8);
        @(negedge clock); in_valid = 0; #4;
        chk("after_rst_add_valid", out_valid, 1);
        chk("after_rst_x1", out_rs1_data, 0);

        // x0 write ignored, rd=0 never stalls, back-to-back issue, unknown opcode
        @(negedge clock); wb_valid = 1; wb_reg = 5'd0; wb_data = 32'hDEAD;
        @(negedge clock); wb_valid = 0; put(20'h600, 32'h00000013);
        @(negedge clock); put(20'h604, 32'h00000013); #4;
        chk("nop1_valid", out_valid, 1);
        chk("x0_read", out_rs1_data, 0);
        chk("nop_rd_we", out_rd_we, 0);
        @(negedge clock); put(20'h608, 32'hFFFFFFFF); #4;
        chk("nop2_valid", out_valid, 1);
        chk("nop2_pc", out_pc, 20'h604);
        @(negedge clock); in_valid = 0; #4;
        chk("unk_valid", out_valid, 1);
        chk("unk_imm", out_imm, 0);
        chk("unk_rd_we", out_rd_we, 0);

        // set beats clear: issue addi x9 while write-back clears x9
        @(negedge clock); put(20'h700, 32'h00300493);
        @(negedge clock); put(20'h704, 32'h00048513);
        wb_valid = 1; wb_reg = 5'd9; wb_data = 32'h55;
        @(negedge clock); in_valid = 0; wb_valid = 0; #4;
        chk("setwins_stall", out_valid, 0);
        @(negedge clock); #4;
        chk("setwins_stall2", out_valid, 0);
        @(negedge clock); wb_valid = 1; wb_reg = 5'd9; wb_data = 32'h66;
        @(negedge clock); wb_valid = 0;
        repeat (4) @(negedge clock);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
